nibble_serial_add_ctrl: RTL and testbench
=========================================

// Module: nibble_serial_add_ctrl
// PURPOSE
// - Sequencer that computes a WIDTH-bit sum {cout,sum} = a + b + cin.
// - Does this over WIDTH/4 cycles with one shared 4-bit cla instance
//   (A,B,Cin -> S,Cout), one nibble per cycle, LSB nibble first.
// - Carry is kept in a register between nibbles.
// - valid/ready on both input and output; front end for wide adds built on
//   the 4-bit adder library.
// PARAMETERS
// - WIDTH  16  operand width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
// - NIB    WIDTH/4 (localparam)  number of nibble steps per operation
// PORTS
// - clk        in   1      single clock; all state updates on rising edge
// - rst        in   1      asynchronous, active-high reset
// - in_valid   in   1      operands a/b/cin valid
// - in_ready   out  1      block can accept an operation (high only in IDLE)
// - a          in   WIDTH  operand A; sampled only on accept
// - b          in   WIDTH  operand B; sampled only on accept
// - cin        in   1      carry-in; sampled only on accept
// - out_valid  out  1      result valid (high only in DONE)
// - out_ready  in   1      consumer accepts result
// - sum        out  WIDTH  result, registered
// - cout       out  1      carry out of MSB, registered
// - busy       out  1      high in RUN or DONE
// - ovf        out  1      signed overflow (only with SIGNED_OVF_EN)
// BEHAVIOUR
// Reset
// - rst high: state=IDLE, idx=0, carry=0, op regs=0, sum=0, cout=0, ovf=0, out_valid=0, busy=0.
// - in_ready=1, since in_ready = (state==IDLE).
// FSM IDLE
// - Accept = in_valid && in_ready at an edge.
// - On accept: latch a, b; carry<=cin; idx<=0; clear sum/cout; go RUN.
// FSM RUN
// - Each edge: cla.A=a_q[4*idx+:4], cla.B=b_q[4*idx+:4], cla.Cin=carry.
// - sum[4*idx+:4]<=S; carry<=Cout; idx<=idx+1.
// - On idx==NIB-1: cout<=Cout; go DONE.
// FSM DONE
// - out_valid=1; sum/cout/ovf held stable.
// - out_valid && out_ready at an edge: go IDLE, so in_ready=1 in the next cycle.
// Latency and throughput
// - Accept at edge T -> out_valid high after edge T+NIB.
// - Earliest next accept is edge T+NIB+2 (one op per NIB+2 cycles).
// - WIDTH=4 gives a single RUN cycle.
// Input rules
// - in_valid and a/b/cin are ignored outside IDLE.
// - Operands need be stable only in the accept cycle.
// Output rules
// - out_ready is ignored outside DONE.
// - Backpressure is unbounded; outputs hold.
// Reset mid-operation
// - Aborts immediately to the reset values above.
// - A partial sum is never presented; out_valid never pulses.
// Width rule
// - Result is mod 2^WIDTH in sum, carry in cout.
// - {cout,sum} must equal a+b+cin as a WIDTH+1-bit value.
// CONFIGURATION
// SIGNED_OVF_EN defined
// - Port ovf exists.
// - On the final RUN step: ovf <= (a_q[W-1]==b_q[W-1]) && (S[3]!=a_q[W-1]).
// - Held in DONE; cleared on accept and on reset.
// SIGNED_OVF_EN undefined
// - Port ovf and its logic are absent; all other behaviour is identical.
// TESTING  (WIDTH=16)
// - Reset: after rst pulse -> out_valid=0, busy=0, in_ready=1, sum=0000, cout=0.
// - a=FFFF b=0001 cin=0: out_valid exactly 4 cycles after accept -> sum=0000 cout=1.
// - a=AAAA b=5555 cin=1 -> sum=0000 cout=1; a=0000 b=0000 cin=0 -> sum=0000 cout=0.
// - Backpressure: a=1234 b=1111 cin=0, out_ready=0 for 5 cycles, in_valid pulsed meanwhile:
//   - sum=2345 held, out_valid stays 1, no new accept.
//   - After out_ready=1, in_ready=1 next cycle.
// - Reset mid-RUN: assert rst after 2 nibble steps of a=0FFF b=0001:
//   - All outputs at reset values immediately.
//   - Next op a=0001 b=0002 -> sum=0003.
// - SIGNED_OVF_EN: 7FFF+0001 -> sum=8000 ovf=1 cout=0; FFFF+0001 -> ovf=0 cout=1.
// - Random: 1000 ops, random out_ready -> {cout,sum}==a+b+cin every op.

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: serial WIDTH-bit adder that computes {cout,sum} = a + b + cin.
// It reuses one 4-bit carry-lookahead adder and processes one nibble per cycle,
// starting with the least significant nibble. A carry register links the nibbles.
// The input side uses a valid/ready handshake, and so does the output side.
// Optional feature macro: SIGNED_OVF_EN adds the 'ovf' port and signed overflow detection.

// 4-bit carry-lookahead adder: the building block the sequencer shares across nibbles
module nibble_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout
);

  logic [3:0] gen;
  logic [3:0] prop;
  logic [4:0] c;

  // Generate/propagate terms; every carry is expanded straight from cin
  always_comb begin
    gen  = a & b;
    prop = a ^ b;
    c[0] = cin;
    c[1] = gen[0] | (prop[0] & cin);
    c[2] = gen[1] | (prop[1] & gen[0]) | (prop[1] & prop[0] & cin);
    c[3] = gen[2] | (prop[2] & gen[1]) | (prop[2] & prop[1] & gen[0])
         | (prop[2] & prop[1] & prop[0] & cin);
    c[4] = gen[3] | (prop[3] & gen[2]) | (prop[3] & prop[2] & gen[1])
         | (prop[3] & prop[2] & prop[1] & gen[0])
         | (prop[3] & prop[2] & prop[1] & prop[0] & cin);
    s    = prop ^ c[3:0];
    cout = c[4];
  end

endmodule

module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SIGNED_OVF_EN
  output logic             ovf,
`endif
  output logic             busy
);

  localparam int NIB  = WIDTH / 4;
  localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

  // Stop elaboration if the operand cannot be split into whole nibbles
  if ((WIDTH < 4) || ((WIDTH % 4) != 0)) begin : g_width_check
    $error("nibble_serial_add_ctrl: WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [IDXW-1:0]   idx;
  logic              carry;
  logic [WIDTH-1:0]  a_q;
  logic [WIDTH-1:0]  b_q;
  logic [3:0]        nib_a;
  logic [3:0]        nib_b;
  logic [3:0]        cla_s;
  logic              cla_cout;
  logic              accept;
  logic              step;
  logic              last_step;

  // Accepting only in IDLE means any in_valid seen in RUN/DONE is ignored
  assign accept    = in_valid && (state == IDLE);
  assign step      = (state == RUN);
  assign last_step = (idx == IDXW'(NIB - 1));

  // Select the nibble pair addressed by idx for the shared adder
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int i = 0; i < NIB; i++) begin
      if (idx == IDXW'(i)) begin
        nib_a = a_q[4*i +: 4];
        nib_b = b_q[4*i +: 4];
      end
    end
  end

  nibble_cla4 u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .s    (cla_s),
    .cout (cla_cout)
  );

  // State register; reset aborts any operation in progress
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and handshake outputs, all derived from the current state
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands are captured once at accept so callers need hold them only for that cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
    end else if (accept) begin
      a_q <= a;
      b_q <= b;
    end
  end

  // Nibble index and inter-nibble carry advance one step per RUN cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx   <= '0;
      carry <= 1'b0;
    end else if (accept) begin
      idx   <= '0;
      carry <= cin;
    end else if (step) begin
      idx   <= idx + 1'b1;
      carry <= cla_cout;
    end
  end

  // Result assembly: sum fills one nibble per step, cout takes the last nibble's carry
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (accept) begin
      sum  <= '0;
      cout <= 1'b0;
    end else if (step) begin
      for (int i = 0; i < NIB; i++) begin
        if (idx == IDXW'(i)) begin
          sum[4*i +: 4] <= cla_s;
        end
      end
      if (last_step) begin
        cout <= cla_cout;
      end
    end
  end

`ifdef SIGNED_OVF_EN
  // Signed overflow: operands agree in sign but the result's MSB differs from them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (accept) begin
      ovf <= 1'b0;
    end else if (step && last_step) begin
      ovf <= (a_q[WIDTH-1] == b_q[WIDTH-1]) && (cla_s[3] != a_q[WIDTH-1]);
    end
  end
`endif

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: bench for nibble_serial_add_ctrl with WIDTH=16.
// It models the design as a transaction: accept, NIB busy cycles, then a result
// held until it is consumed. It also runs directed operations with literal results.
// Optional feature macro: SIGNED_OVF_EN (enables ovf connection and checks).
module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SIGNED_OVF_EN
  logic             ovf;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
`ifdef SIGNED_OVF_EN
    .ovf       (ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Transaction model: exact arithmetic plus a cycle countdown for the busy phase
  logic [WIDTH:0] nxt_exp;
  logic           nxt_ovf;
  logic           m_idle    = 1'b1;
  logic           m_done    = 1'b0;
  int             m_cnt     = 0;
  logic [WIDTH:0] m_exp     = '0;
  logic           m_ovf     = 1'b0;
  int             m_accepts = 0;

  assign nxt_exp = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign nxt_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (nxt_exp[WIDTH-1] != a[WIDTH-1]);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_idle <= 1'b1;
      m_done <= 1'b0;
      m_cnt  <= 0;
    end else if (m_idle) begin
      if (in_valid) begin
        m_exp     <= nxt_exp;
        m_ovf     <= nxt_ovf;
        m_cnt     <= NIB;
        m_idle    <= 1'b0;
        m_accepts <= m_accepts + 1;
      end
    end else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end else if (m_done && out_ready) begin
      m_done <= 1'b0;
      m_idle <= 1'b1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, got, exp);
  endtask

  // Compare DUT against the model on every falling edge
  always @(negedge clk) begin
    checkOutput("cmp_in_ready", 32'(in_ready), 32'(m_idle));
    checkOutput("cmp_out_valid", 32'(out_valid), 32'(m_done));
    checkOutput("cmp_busy", 32'(busy), 32'(!m_idle));
    if (m_done) begin
      checkOutput("cmp_sum", 32'(sum), 32'(m_exp[WIDTH-1:0]));
      checkOutput("cmp_cout", 32'(cout), 32'(m_exp[WIDTH]));
`ifdef SIGNED_OVF_EN
      checkOutput("cmp_ovf", 32'(ovf), 32'(m_ovf));
`endif
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv);
    int waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("accept_wait", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    cin      = cv;
    tick();
    in_valid = 1'b0;
    a        = 16'($urandom);
    b        = 16'($urandom);
    cin      = 1'($urandom);
  endtask

  task automatic runOp(input string name, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                       input logic cv, input logic [WIDTH-1:0] exp_sum, input logic exp_cout);
    int cycles = 0;
    applyStimulus(av, bv, cv);
    while (!out_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    checkOutput({name, "_latency"}, 32'(cycles), 32'(NIB));
    checkOutput({name, "_sum"}, 32'(sum), 32'(exp_sum));
    checkOutput({name, "_cout"}, 32'(cout), 32'(exp_cout));
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("consume_in_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int start;
    int cyc;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    checkOutput("reset_sum", 32'(sum), 32'h0000);
    checkOutput("reset_cout", 32'(cout), 32'd0);

    runOp("ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
    consume();
    runOp("aaaa_5555_c", 16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1);
    consume();
    runOp("zero", 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    consume();
    runOp("1234_4321", 16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0);
    consume();
    runOp("8000_8000", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1);
    consume();
    runOp("ffff_ffff_c", 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1);
    consume();

    runOp("ovf_7fff", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0);
`ifdef SIGNED_OVF_EN
    checkOutput("ovf_7fff_flag", 32'(ovf), 32'd1);
`endif
    consume();
    runOp("ovf_ffff", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1);
`ifdef SIGNED_OVF_EN
    checkOutput("ovf_ffff_flag", 32'(ovf), 32'd0);
`endif
    consume();

    // Backpressure: result must hold and new requests must be ignored
    runOp("bp", 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      a        = 16'($urandom);
      b        = 16'($urandom);
      tick();
      checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
      checkOutput("bp_sum", 32'(sum), 32'h2345);
      checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    consume();
    checkOutput("bp_sum_held_idle", 32'(sum), 32'h2345);

    // Reset in the middle of an operation, after two nibble steps
    applyStimulus(16'h0FFF, 16'h0001, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_in_ready", 32'(in_ready), 32'd1);
    checkOutput("midrst_sum", 32'(sum), 32'h0000);
    checkOutput("midrst_cout", 32'(cout), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    runOp("after_rst", 16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0);
    consume();

    // Random traffic with random consumer readiness
    start = m_accepts;
    cyc   = 0;
    while ((m_accepts - start) < 1000 && cyc < 40000) begin
      in_valid  = 1'($urandom);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      out_ready = 1'($urandom);
      tick();
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checkOutput("random_op_count", 32'(m_accepts - start), 32'd1000);
    for (int i = 0; i < 8; i++) tick();
    checkOutput("drain_in_ready", 32'(in_ready), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
